uart_apb_if: RTL and testbench

//  APB3 slave front-end that sits directly upstream of the uart block. It decodes CPU

---
 rtl/uart_apb_if_pkg.sv | 26 ++
 rtl/uart_apb_if_if.sv | 27 ++
 rtl/uart_apb_if.sv | 141 ++++++++++++++
 tb/tb_uart_apb_if.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_if_pkg.sv
// Shared definitions for the uart APB front-end: register indices, ERR bit
// positions, bus widths and FSM state encoding.
package uart_apb_if_pkg;

    localparam int unsigned APB_AW = 4;   // byte address width on the APB side
    localparam int unsigned IDX_W  = 2;   // register word-index width

    // Register word indices (PADDR[3:2])
    localparam logic [IDX_W-1:0] REG_DATA   = 2'd0;
    localparam logic [IDX_W-1:0] REG_STATUS = 2'd1;
    localparam logic [IDX_W-1:0] REG_BAUD   = 2'd2;
    localparam logic [IDX_W-1:0] REG_ERR    = 2'd3;

    // Sticky ERR register bit positions
    localparam int unsigned ERR_RX_UNDER = 0;
    localparam int unsigned ERR_TX_OVER  = 1;
    localparam int unsigned ERR_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/uart_apb_if_if.sv
// APB3 bus bundle between the CPU side (master) and uart_apb_if (slave).
//  PSEL/PENABLE/PWRITE/PADDR/PWDATA : master -> slave request
//  PRDATA/PREADY/PSLVERR            : slave -> master response
interface uart_apb_if_if
    import uart_apb_if_pkg::*;
#(
    parameter int unsigned DW = 8
) ();
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_apb_if.sv
// APB3 slave front-end for the uart block. Decodes register accesses and
// drives the uart host-side controls.
//  clk, reset_n          : system clock, async active-low reset
//  apb (slave)           : APB3 request/response bundle
//  w_data, wr_uart       : tx byte and one-cycle push strobe to uart
//  rd_uart, r_data       : one-cycle pop strobe and rx byte from uart
//  rx_empty, tx_full     : uart buffer status
//  uart_paddr            : latched word index forwarded to uart
//  TIMER_FINAL_VALUE     : baud divisor register
module uart_apb_if
    import uart_apb_if_pkg::*;
#(
    parameter int unsigned   DW       = 8,
    parameter logic [DW-1:0] BAUD_RST = 8'd163
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_apb_if_if.slave     apb,
    output logic [DW-1:0]    w_data,
    output logic             wr_uart,
    output logic             rd_uart,
    input  logic [DW-1:0]    r_data,
    input  logic             rx_empty,
    input  logic             tx_full,
    output logic [IDX_W-1:0] uart_paddr,
    output logic [DW-1:0]    TIMER_FINAL_VALUE
);

    state_t           state;
    logic [ERR_W-1:0] err;
    logic [ERR_W-1:0] err_set;
    logic [ERR_W-1:0] err_clr;
    logic [IDX_W-1:0] idx;
    logic             setup;
    logic [DW-1:0]    rd_mux;
    logic             unused_paddr;

    assign idx          = apb.PADDR[3:2];
    assign unused_paddr = ^apb.PADDR[1:0];

    // The whole transfer is decided at the setup edge so that PREADY can be a
    // register yet still be high in the very first access cycle.
    assign setup = (state == ST_IDLE) && apb.PSEL && !apb.PENABLE;

    // Sticky error set/clear terms; set wins over clear
    always_comb begin
        err_set = '0;
        err_clr = '0;
        if (setup) begin
            if (apb.PWRITE && (idx == REG_DATA) && tx_full) begin
                err_set[ERR_TX_OVER] = 1'b1;
            end
            if (!apb.PWRITE && (idx == REG_DATA) && rx_empty) begin
                err_set[ERR_RX_UNDER] = 1'b1;
            end
            if (apb.PWRITE && (idx == REG_ERR)) begin
                err_clr = apb.PWDATA[ERR_W-1:0];
            end
        end
    end

    // Read mux for the zero-wait-state registers; DATA underflow reads 0
    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_STATUS: rd_mux = DW'({(err != '0), tx_full, rx_empty});
            REG_BAUD:   rd_mux = TIMER_FINAL_VALUE;
            REG_ERR:    rd_mux = DW'(err);
            default:    rd_mux = '0;
        endcase
    end

    // Transfer FSM with registered bus responses and uart strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            apb.PRDATA        <= '0;
            apb.PREADY        <= 1'b0;
            apb.PSLVERR       <= 1'b0;
            wr_uart           <= 1'b0;
            rd_uart           <= 1'b0;
            w_data            <= '0;
            uart_paddr        <= '0;
            TIMER_FINAL_VALUE <= BAUD_RST;
            err               <= '0;
        end else begin
            wr_uart <= 1'b0;
            rd_uart <= 1'b0;
            err     <= (err & ~err_clr) | err_set;
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state      <= ST_ACCESS;
                        uart_paddr <= idx;
                        if (apb.PWRITE) begin
                            apb.PREADY <= 1'b1;
                            case (idx)
                                REG_DATA: begin
                                    if (tx_full) begin
                                        apb.PSLVERR <= 1'b1;
                                    end else begin
                                        wr_uart <= 1'b1;
                                        w_data  <= apb.PWDATA;
                                    end
                                end
                                REG_BAUD: TIMER_FINAL_VALUE <= apb.PWDATA;
                                default: ;
                            endcase
                        end else if ((idx == REG_DATA) && !rx_empty) begin
                            // Pop now, return the byte after one wait state
                            rd_uart <= 1'b1;
                        end else begin
                            apb.PREADY  <= 1'b1;
                            apb.PRDATA  <= rd_mux;
                            apb.PSLVERR <= (idx == REG_DATA);
                        end
                    end
                end
                ST_ACCESS: begin
                    if (rd_uart) begin
                        state      <= ST_RD_WAIT;
                        apb.PRDATA <= r_data;
                        apb.PREADY <= 1'b1;
                    end else begin
                        state       <= ST_DONE;
                        apb.PREADY  <= 1'b0;
                        apb.PSLVERR <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    state       <= ST_DONE;
                    apb.PREADY  <= 1'b0;
                    apb.PSLVERR <= 1'b0;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_if.sv
// Self-checking bench for uart_apb_if: directed cases then random APB traffic,
// with a scoreboard monitor comparing responses and strobes to a register model.
module tb_uart_apb_if;
    import uart_apb_if_pkg::*;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] w_data;
    logic          wr_uart;
    logic          rd_uart;
    logic [DW-1:0] r_data;
    logic          rx_empty;
    logic          tx_full;
    logic [1:0]    uart_paddr;
    logic [DW-1:0] tfv;

    always #5 clk = ~clk;

    uart_apb_if_if #(.DW(DW)) apb ();

    uart_apb_if #(.DW(DW), .BAUD_RST(8'd163)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .apb               (apb.slave),
        .w_data            (w_data),
        .wr_uart           (wr_uart),
        .rd_uart           (rd_uart),
        .r_data            (r_data),
        .rx_empty          (rx_empty),
        .tx_full           (tx_full),
        .uart_paddr        (uart_paddr),
        .TIMER_FINAL_VALUE (tfv)
    );

    typedef struct packed {
        logic       is_rd;
        logic [7:0] data;
        logic       err;
    } resp_t;

    resp_t      exp_q[$];
    logic [7:0] wr_q[$];
    int         n_cmp  = 0;
    int         n_err  = 0;
    int         rd_seen = 0;
    int         rd_exp  = 0;
    bit         mon_en = 1'b0;
    logic [7:0] m_baud = 8'd163;
    logic [1:0] m_err  = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event, expected none at %0t", name, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer or strobes
    always @(negedge clk) begin
        if (mon_en) begin
            resp_t r;
            check("strobe_exclusive", 32'(wr_uart & rd_uart), 32'd0);
            if (!apb.PREADY) begin
                check("pslverr_idle", 32'(apb.PSLVERR), 32'd0);
            end else if (exp_q.size() == 0) begin
                fail_now("unexpected_pready");
            end else begin
                r = exp_q.pop_front();
                check("pslverr", 32'(apb.PSLVERR), 32'(r.err));
                if (r.is_rd) check("prdata", 32'(apb.PRDATA), 32'(r.data));
            end
            if (wr_uart) begin
                if (wr_q.size() == 0) fail_now("unexpected_wr_uart");
                else check("w_data", 32'(w_data), 32'(wr_q.pop_front()));
            end
            if (rd_uart) rd_seen++;
        end
    end

    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                            output int waits);
        @(posedge clk); #1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wd;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (apb.PREADY) break;
            waits++;
            if (waits > 8) begin
                check("pready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    // Register-level model: computes the expected response, then runs the transfer
    task automatic do_xfer(input logic wr, input logic [1:0] idx, input logic [7:0] wd,
                           input logic txf, input logic rxe, input logic [7:0] rd);
        resp_t r;
        int    waits;
        int    exp_waits;
        exp_waits = 0;
        tx_full   = txf;
        rx_empty  = rxe;
        r_data    = rd;
        r.is_rd   = !wr;
        r.data    = 8'h00;
        r.err     = 1'b0;
        case (idx)
            REG_DATA: begin
                if (wr) begin
                    if (txf) begin r.err = 1'b1; m_err[1] = 1'b1; end
                    else wr_q.push_back(wd);
                end else begin
                    if (rxe) begin r.err = 1'b1; m_err[0] = 1'b1; end
                    else begin r.data = rd; rd_exp++; exp_waits = 1; end
                end
            end
            REG_STATUS: if (!wr) r.data = {5'b0, (m_err != 2'b00), txf, rxe};
            REG_BAUD: begin
                if (wr) m_baud = wd;
                else r.data = m_baud;
            end
            default: begin
                if (wr) m_err = m_err & ~wd[1:0];
                else r.data = {6'b0, m_err};
            end
        endcase
        exp_q.push_back(r);
        apb_xfer(wr, {idx, 2'b00}, wd, waits);
        check("wait_states", 32'(waits), 32'(exp_waits));
        check("timer_final_value", 32'(tfv), 32'(m_baud));
        check("uart_paddr", 32'(uart_paddr), 32'(idx));
    endtask

    task automatic check_reset_values();
        check("rst_prdata", 32'(apb.PRDATA), 32'd0);
        check("rst_pready", 32'(apb.PREADY), 32'd0);
        check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
        check("rst_wr_uart", 32'(wr_uart), 32'd0);
        check("rst_rd_uart", 32'(rd_uart), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_uart_paddr", 32'(uart_paddr), 32'd0);
        check("rst_timer", 32'(tfv), 32'd163);
    endtask

    initial begin
        reset_n     = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 4'h0;
        apb.PWDATA  = 8'h00;
        r_data      = 8'h00;
        rx_empty    = 1'b1;
        tx_full     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Directed: DATA write, DATA read, underflow + STATUS/ERR, overflow, BAUD
        do_xfer(1'b1, REG_DATA,   8'hA5, 1'b0, 1'b1, 8'h00);
        do_xfer(1'b0, REG_DATA,   8'h00, 1'b0, 1'b0, 8'h3C);
        do_xfer(1'b0, REG_DATA,   8'h00, 1'b0, 1'b1, 8'h77);
        do_xfer(1'b0, REG_STATUS, 8'h00, 1'b0, 1'b1, 8'h00);
        do_xfer(1'b1, REG_ERR,    8'h01, 1'b0, 1'b1, 8'h00);
        do_xfer(1'b0, REG_STATUS, 8'h00, 1'b0, 1'b1, 8'h00);
        do_xfer(1'b1, REG_DATA,   8'h5A, 1'b1, 1'b0, 8'h00);
        do_xfer(1'b0, REG_ERR,    8'h00, 1'b1, 1'b0, 8'h00);
        do_xfer(1'b1, REG_STATUS, 8'hFF, 1'b0, 1'b0, 8'h00);
        do_xfer(1'b1, REG_BAUD,   8'd10, 1'b0, 1'b0, 8'h00);
        do_xfer(1'b0, REG_BAUD,   8'h00, 1'b0, 1'b0, 8'h00);
        do_xfer(1'b1, REG_BAUD,   8'd0,  1'b0, 1'b0, 8'h00);
        do_xfer(1'b1, REG_BAUD,   8'h55, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a DATA write: strobe must drop immediately
        mon_en = 1'b0;
        @(posedge clk); #1;
        tx_full     = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 4'h0;
        apb.PWDATA  = 8'hC3;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        check("pre_reset_wr_uart", 32'(wr_uart), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        exp_q.delete();
        wr_q.delete();
        m_baud = 8'd163;
        m_err  = 2'b00;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        do_xfer(1'b0, REG_BAUD, 8'h00, 1'b0, 1'b0, 8'h00);
        do_xfer(1'b0, REG_ERR,  8'h00, 1'b0, 1'b0, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            do_xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    8'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rd_uart_count", 32'(rd_seen), 32'(rd_exp));
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
